// File: rtl/intersection_sequencer_if.sv
// Signal bundle between the traffic-light FSM/sensor side and the timing sequencer.
// The FSM side drives phase and the raw sensor; the sequencer returns the decision inputs.
interface intersection_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             SN;
    logic [2:0]       phase;
    logic             T;
    logic             L;
    logic             S;
    logic [CNT_W-1:0] count;
    logic             phase_err;

    modport master (
        output SN,
        output phase,
        input  T,
        input  L,
        input  S,
        input  count,
        input  phase_err
    );

    modport slave (
        input  SN,
        input  phase,
        output T,
        output L,
        output S,
        output count,
        output phase_err
    );
endinterface

// File: rtl/intersection_sequencer.sv
// Per-phase timer, highway long-window timer and debounced farm sensor feeding
// the 5-phase traffic-light FSM (R, HG, HY, FG, FY).
module intersection_sequencer #(
    parameter int CNT_W       = 8,
    parameter int RED_CYC     = 4,
    parameter int YEL_CYC     = 3,
    parameter int FG_CYC      = 8,
    parameter int HG_TICK_CYC = 4,
    parameter int HG_LONG_CYC = 16,
    parameter int DEB_CYC     = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    intersection_sequencer_if.slave bus
);
    localparam logic [2:0] PH_R  = 3'd0;
    localparam logic [2:0] PH_HG = 3'd1;
    localparam logic [2:0] PH_HY = 3'd2;
    localparam logic [2:0] PH_FG = 3'd3;
    localparam logic [2:0] PH_FY = 3'd4;
    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [2:0]       prev_phase_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] long_cnt_r;
    logic             phase_err_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             s_r;
    logic [DEB_W-1:0] deb_cnt_r;

    logic [CNT_W-1:0] dur_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             illegal_s;
    logic             chg_s;
    logic             is_hg_s;

    assign chg_s   = (bus.phase != prev_phase_r);
    assign is_hg_s = (bus.phase == PH_HG);

    // Phase duration lookup; illegal codes fall back to the all-red time.
    always_comb begin
        dur_s     = CNT_W'(RED_CYC);
        illegal_s = 1'b0;
        case (bus.phase)
            PH_R:         dur_s = CNT_W'(RED_CYC);
            PH_HG:        dur_s = CNT_W'(HG_TICK_CYC);
            PH_HY, PH_FY: dur_s = CNT_W'(YEL_CYC);
            PH_FG:        dur_s = CNT_W'(FG_CYC);
            default: begin
                dur_s     = CNT_W'(RED_CYC);
                illegal_s = 1'b1;
            end
        endcase
    end

    // Down-counter next value: a phase change outranks the HG periodic reload.
    always_comb begin
        count_nxt_s = count_r;
        if (chg_s) begin
            count_nxt_s = dur_s - CNT_W'(1);
        end else if ((count_r == CNT_W'(0)) && is_hg_s) begin
            count_nxt_s = CNT_W'(HG_TICK_CYC - 1);
        end else if (count_r != CNT_W'(0)) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Phase tracking, phase counter, long-window counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_phase_r <= PH_R;
            count_r      <= CNT_W'(RED_CYC - 1);
            long_cnt_r   <= CNT_W'(0);
            phase_err_r  <= 1'b0;
        end else begin
            prev_phase_r <= bus.phase;
            count_r      <= count_nxt_s;
            phase_err_r  <= phase_err_r | illegal_s;
            if (chg_s || !is_hg_s) begin
                long_cnt_r <= CNT_W'(0);
            end else if (long_cnt_r != CNT_W'(HG_LONG_CYC)) begin
                long_cnt_r <= long_cnt_r + CNT_W'(1);
            end else begin
                long_cnt_r <= long_cnt_r;
            end
        end
    end

    // Two-flop synchroniser followed by a consecutive-cycle debouncer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            s_r       <= 1'b0;
            deb_cnt_r <= DEB_W'(0);
        end else begin
            sync1_r <= bus.SN;
            sync2_r <= sync1_r;
            if (sync2_r == s_r) begin
                deb_cnt_r <= DEB_W'(0);
            end else if (deb_cnt_r == DEB_W'(DEB_CYC - 1)) begin
                s_r       <= sync2_r;
                deb_cnt_r <= DEB_W'(0);
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end
        end
    end

    // T and L are masked in a change cycle so a stale count never leaks into the new phase.
    assign bus.T         = (count_r == CNT_W'(0)) && !chg_s;
    assign bus.L         = is_hg_s && !chg_s && (long_cnt_r == CNT_W'(HG_LONG_CYC));
    assign bus.S         = s_r;
    assign bus.count     = count_r;
    assign bus.phase_err = phase_err_r;
endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed and randomized bench for intersection_sequencer, scored against a
// phase-age / sensor-window reference model.
module tb_intersection_sequencer;
    localparam int CNT_W = 8;
    localparam int RED   = 4;
    localparam int YEL   = 3;
    localparam int FGC   = 8;
    localparam int HGT   = 4;
    localparam int HGL   = 16;
    localparam int DEB   = 3;

    logic clk = 1'b0;
    logic reset;

    intersection_sequencer_if #(.CNT_W(CNT_W)) bus ();

    intersection_sequencer #(
        .CNT_W(CNT_W), .RED_CYC(RED), .YEL_CYC(YEL), .FG_CYC(FGC),
        .HG_TICK_CYC(HGT), .HG_LONG_CYC(HGL), .DEB_CYC(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase age since entry plus a sliding window of synchronised sensor samples.
    int prev_m, age_m, s_m, h1_m, h2_m, err_m;
    int win_q[$];
    logic obs_T, obs_L, obs_S;

    function automatic int dur(input int p);
        case (p)
            0:       return RED;
            1:       return HGT;
            2, 4:    return YEL;
            3:       return FGC;
            default: return RED;
        endcase
    endfunction

    function automatic int fsm_next(input int p, input logic t, input logic l, input logic s);
        case (p)
            0:       return t ? (s ? 3 : 1) : 0;
            1:       return (t && l && s) ? 2 : 1;
            2:       return t ? 0 : 2;
            3:       return t ? 4 : 3;
            4:       return t ? 0 : 4;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        prev_m = 0; age_m = 1; s_m = 0; h1_m = 0; h2_m = 0; err_m = 0;
        win_q.delete();
    endtask

    // One clock cycle: called just after a negedge with inputs already applied.
    task automatic step(input string tag);
        int p, a, d, texp, lexp, cexp;
        bit chg, all_diff;
        #1;
        p   = int'(bus.phase);
        chg = (p != prev_m);
        a   = chg ? 0 : age_m;
        d   = dur(p);
        if (chg) texp = 0;
        else if (p == 1) texp = (a % d == 0) ? 1 : 0;
        else texp = (a >= d) ? 1 : 0;
        lexp = (p == 1 && !chg && a >= HGL + 1) ? 1 : 0;
        obs_T = bus.T; obs_L = bus.L; obs_S = bus.S;
        chk({tag, ".T"}, bus.T, texp);
        chk({tag, ".L"}, bus.L, lexp);
        chk({tag, ".S"}, bus.S, s_m);
        chk({tag, ".err"}, bus.phase_err, err_m);
        if (!chg) begin
            if (p == 1) cexp = (a % d == 0) ? 0 : d - (a % d);
            else cexp = (a >= d) ? 0 : d - a;
            chk({tag, ".count"}, bus.count, cexp);
        end
        @(posedge clk);
        if (p > 4) err_m = 1;
        prev_m = p;
        age_m  = (a < 100000) ? a + 1 : a;
        win_q.push_back(h2_m);
        if (win_q.size() > DEB) void'(win_q.pop_front());
        if (win_q.size() == DEB) begin
            all_diff = 1'b1;
            foreach (win_q[i]) if (win_q[i] == s_m) all_diff = 1'b0;
            if (all_diff) s_m = h2_m;
        end
        h2_m = h1_m;
        h1_m = int'(bus.SN);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, held across two edges, released at a negedge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        chk({tag, ".count"}, bus.count, RED - 1);
        chk({tag, ".T"}, bus.T, 0);
        chk({tag, ".L"}, bus.L, 0);
        chk({tag, ".S"}, bus.S, 0);
        chk({tag, ".err"}, bus.phase_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({tag, ".count_hold"}, bus.count, RED - 1);
        chk({tag, ".S_hold"}, bus.S, 0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int run_len, cur, nxt;
        reset     = 1'b1;
        bus.phase = 3'd0;
        bus.SN    = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset("rst0");

        // Phase R held after reset: T rises once the all-red time has elapsed.
        for (int i = 0; i < 6; i++) step("red");
        chk("red.count_zero", bus.count, 0);

        // Sensor glitch shorter than the debounce window is dropped.
        bus.SN = 1'b1;
        step("glitch"); step("glitch");
        bus.SN = 1'b0;
        for (int i = 0; i < 8; i++) step("glitch");
        chk("glitch.S_low", obs_S, 0);

        // Held sensor edge reaches S after exactly DEB+2 cycles.
        bus.SN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step("deb");
            if (i == DEB + 1) chk("deb.S_before", obs_S, 0);
            if (i == DEB + 2) chk("deb.S_at", obs_S, 1);
        end

        // Highway green: periodic T pulses, L after the long window, L drops on exit.
        bus.phase = 3'd1;
        for (int i = 0; i < 24; i++) step("hg");
        chk("hg.L_high", obs_L, 1);
        bus.phase = 3'd2;
        step("hy");
        chk("hy.L_drop", obs_L, 0);
        for (int i = 0; i < 4; i++) step("hy");

        // Closed loop with sensor active: R -> FG -> FY -> R with exact dwell times.
        bus.phase = 3'd0;
        cur = 0;
        run_len = 0;
        for (int i = 0; i < 45; i++) begin
            step("cl1");
            run_len++;
            nxt = fsm_next(cur, obs_T, obs_L, obs_S);
            if (nxt != cur) begin
                case (cur)
                    0:       chk("cl1.R_len", run_len, RED + 1);
                    3:       chk("cl1.FG_len", run_len, FGC + 1);
                    4:       chk("cl1.FY_len", run_len, YEL + 1);
                    default: chk("cl1.phase", cur, 0);
                endcase
                cur = nxt;
                bus.phase = 3'(nxt);
                run_len = 0;
            end
        end

        // Closed loop with sensor idle: the FSM settles in HG and stays there.
        bus.SN = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step("cl2");
            nxt = fsm_next(cur, obs_T, obs_L, obs_S);
            cur = nxt;
            bus.phase = 3'(nxt);
        end
        chk("cl2.hg_hold", bus.phase, 1);

        // Randomized legal phase sequences and sensor activity.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 2) bus.phase = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) bus.SN = ~bus.SN;
            step("rnd");
        end

        // Illegal phase for one cycle: sticky error, counter loads the all-red time.
        bus.phase = 3'd6;
        step("ill");
        chk("ill.count_load", bus.count, RED - 1);
        chk("ill.err_set", bus.phase_err, 1);
        bus.phase = 3'd0;
        for (int i = 0; i < 6; i++) step("ill_after");
        do_reset("rst1");
        chk("rst1.err_clear", bus.phase_err, 0);

        // Reset in the middle of a highway green with S high.
        bus.SN = 1'b1;
        for (int i = 0; i < 8; i++) step("pre");
        bus.phase = 3'd1;
        for (int i = 0; i < 11; i++) step("midhg");
        do_reset("rst2");
        for (int i = 0; i < 8; i++) step("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
